// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants: operand-mux forward selects and the stage-index width.
// The decode scoreboard and the operand mux logic both import this package.
package cpu_pipe_pkg;

  localparam int STG_W = 2;

  typedef enum logic [STG_W-1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/pipeid_scoreboard_if.sv
// ID-stage side of the scoreboard: instruction fields in, interlock and forward selects out.
interface pipeid_scoreboard_if #(
  parameter int RW   = 5,
  parameter int AW   = cpu_pipe_pkg::STG_W,
  parameter int CNTW = 32
);
  logic            adv;
  logic            id_valid;
  logic [RW-1:0]   rs;
  logic [RW-1:0]   rt;
  logic            use_rs;
  logic            use_rt;
  logic            wr_en;
  logic [RW-1:0]   wr_dst;
  logic [AW-1:0]   wr_rdy;
  logic            stall;
  logic            issue;
  logic [AW-1:0]   fwda;
  logic [AW-1:0]   fwdb;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output adv, id_valid, rs, rt, use_rs, use_rt, wr_en, wr_dst, wr_rdy,
    input  stall, issue, fwda, fwdb, stall_cnt
  );

  modport slave (
    input  adv, id_valid, rs, rt, use_rs, use_rt, wr_en, wr_dst, wr_rdy,
    output stall, issue, fwda, fwdb, stall_cnt
  );
endinterface

// File: rtl/pipeid_sb_entry.sv
// One GPR's scoreboard entry: tracks which post-ID stage holds its youngest writer
// and the stage at which that writer's result becomes available.
module pipeid_sb_entry #(
  parameter int AW     = 2,
  parameter int NSTAGE = 3
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          i_adv,
  input  logic          i_load,
  input  logic [AW-1:0] i_rdy,
  output logic          o_busy,
  output logic [AW-1:0] o_age,
  output logic [AW-1:0] o_rdy
);

  logic          r_busy;
  logic [AW-1:0] r_age;
  logic [AW-1:0] r_rdy;

  // NOTE: every entry is cleared by reset; a stale busy bit would stall ID indefinitely.
  // NOTE: non-blocking assignments so all entries update from the same pre-edge state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_busy <= 1'b0;
      r_age  <= '0;
      r_rdy  <= '0;
    end else if (i_adv) begin
      if (i_load) begin
        r_busy <= 1'b1;
        r_age  <= AW'(1);
        r_rdy  <= i_rdy;
      end else if (r_busy) begin
        if (r_age == AW'(NSTAGE)) begin
          r_busy <= 1'b0;
          r_age  <= '0;
        end else begin
          r_age  <= r_age + AW'(1);
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_age  = r_age;
  assign o_rdy  = r_rdy;

endmodule

// File: rtl/pipeid_scoreboard.sv
// Decode-stage interlock and forwarding unit: per-GPR scoreboard, stall/issue,
// operand forward-stage selects and a saturating stall-cycle counter.
module pipeid_scoreboard
  import cpu_pipe_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int RW     = 5,
  parameter int NSTAGE = 3,
  parameter int AW     = STG_W,
  parameter int CNTW   = 32
) (
  input  logic               clk,
  input  logic               clrn,
  pipeid_scoreboard_if.slave sb
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [NREG-1:0]         w_busy;
  logic [NREG-1:0][AW-1:0] w_age;
  logic [NREG-1:0][AW-1:0] w_rdy;
  logic [AW-1:0]           w_rdy_n;
  logic                    w_hit_rs, w_hit_rt;
  logic                    w_wait_rs, w_wait_rt;
  logic [AW-1:0]           w_fwd_a, w_fwd_b;
  logic                    w_stall;
  logic                    w_issue;
  logic                    w_load;
  logic [CNTW-1:0]         r_stall_cnt;

  // Result-ready stage is clamped into 1..NSTAGE before it is recorded.
  always_comb begin
    w_rdy_n = sb.wr_rdy;
    if (sb.wr_rdy == AW'(FWD_RF)) begin
      w_rdy_n = AW'(FWD_EX);
    end else if (int'(sb.wr_rdy) > NSTAGE) begin
      w_rdy_n = AW'(NSTAGE);
    end
  end

  // Register 0 is hard-wired zero and never gets an entry.
  assign w_busy[0] = 1'b0;
  assign w_age[0]  = '0;
  assign w_rdy[0]  = '0;

  assign w_load = w_issue && sb.wr_en && (sb.wr_dst != '0);

  for (genvar i = 1; i < NREG; i++) begin : g_ent
    pipeid_sb_entry #(
      .AW     (AW),
      .NSTAGE (NSTAGE)
    ) u_ent (
      .clk    (clk),
      .clrn   (clrn),
      .i_adv  (sb.adv),
      .i_load (w_load && (sb.wr_dst == RW'(i))),
      .i_rdy  (w_rdy_n),
      .o_busy (w_busy[i]),
      .o_age  (w_age[i]),
      .o_rdy  (w_rdy[i])
    );
  end

  // A busy source either waits (writer not yet at its ready stage) or forwards from its stage.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_hit_rs  = 1'b0;
    w_hit_rt  = 1'b0;
    w_wait_rs = 1'b0;
    w_wait_rt = 1'b0;
    w_fwd_a   = AW'(FWD_RF);
    w_fwd_b   = AW'(FWD_RF);

    if (sb.use_rs && (sb.rs != '0)) w_hit_rs = w_busy[sb.rs];
    if (sb.use_rt && (sb.rt != '0)) w_hit_rt = w_busy[sb.rt];

    w_wait_rs = w_hit_rs && (w_age[sb.rs] < w_rdy[sb.rs]);
    w_wait_rt = w_hit_rt && (w_age[sb.rt] < w_rdy[sb.rt]);

    if (w_hit_rs && !w_wait_rs) w_fwd_a = w_age[sb.rs];
    if (w_hit_rt && !w_wait_rt) w_fwd_b = w_age[sb.rt];
  end

  assign w_stall = sb.id_valid && (w_wait_rs || w_wait_rt);
  // Gated by reset so nothing is reported as issued while the pipeline is being flushed.
  assign w_issue = clrn && sb.id_valid && !w_stall && sb.adv;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_stall_cnt <= '0;
    end else if (sb.adv && w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNTW'(1);
    end
  end

  assign sb.stall     = w_stall;
  assign sb.issue     = w_issue;
  assign sb.fwda      = w_fwd_a;
  assign sb.fwdb      = w_fwd_b;
  assign sb.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeid_scoreboard.sv
// Bench for pipeid_scoreboard: a pipeline-occupancy model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pipeid_scoreboard;
  localparam int NREG   = 32;
  localparam int RW     = 5;
  localparam int NSTAGE = 3;
  localparam int AW     = 2;
  localparam int CNTW   = 3;
  localparam int CMAX   = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  pipeid_scoreboard_if #(.RW(RW), .AW(AW), .CNTW(CNTW)) sb_if ();

  pipeid_scoreboard #(
    .NREG(NREG), .RW(RW), .NSTAGE(NSTAGE), .AW(AW), .CNTW(CNTW)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .sb   (sb_if.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: which instruction occupies each post-ID stage (1=EX .. NSTAGE=WB).
  typedef struct {
    bit v;
    int dst;
    int rdy;
  } slot_t;

  slot_t m_pipe [1:NSTAGE];
  int    m_cnt = 0;

  // Youngest in-flight writer of r = lowest-numbered stage holding it.
  function automatic int src_stage(input bit u, input int r);
    if (!u || r == 0) return 0;
    for (int k = 1; k <= NSTAGE; k++)
      if (m_pipe[k].v && m_pipe[k].dst == r) return k;
    return 0;
  endfunction

  function automatic bit src_wait(input bit u, input int r);
    int k;
    k = src_stage(u, r);
    if (k == 0) return 1'b0;
    return k < m_pipe[k].rdy;
  endfunction

  function automatic int src_fwd(input bit u, input int r);
    int k;
    k = src_stage(u, r);
    if (k == 0) return 0;
    return (k >= m_pipe[k].rdy) ? k : 0;
  endfunction

  function automatic bit exp_stall();
    return sb_if.id_valid && (src_wait(sb_if.use_rs, int'(sb_if.rs)) ||
                              src_wait(sb_if.use_rt, int'(sb_if.rt)));
  endfunction

  function automatic bit exp_issue();
    return clrn && sb_if.id_valid && !exp_stall() && sb_if.adv;
  endfunction

  function automatic slot_t new_slot();
    slot_t s;
    s = '{1'b0, 0, 0};
    if (exp_issue() && sb_if.wr_en && sb_if.wr_dst != '0) begin
      s.v   = 1'b1;
      s.dst = int'(sb_if.wr_dst);
      s.rdy = int'(sb_if.wr_rdy);
      if (s.rdy < 1) s.rdy = 1;
      if (s.rdy > NSTAGE) s.rdy = NSTAGE;
    end
    return s;
  endfunction

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int k = 1; k <= NSTAGE; k++) m_pipe[k] <= '{1'b0, 0, 0};
      m_cnt <= 0;
    end else if (sb_if.adv) begin
      m_pipe[1] <= new_slot();
      for (int k = 2; k <= NSTAGE; k++) m_pipe[k] <= m_pipe[k-1];
      m_cnt <= (exp_stall() && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
    end
  end

  always @(negedge clk) begin
    check("cmp_stall", int'(sb_if.stall), int'(exp_stall()));
    check("cmp_issue", int'(sb_if.issue), int'(exp_issue()));
    check("cmp_fwda",  int'(sb_if.fwda),  src_fwd(sb_if.use_rs, int'(sb_if.rs)));
    check("cmp_fwdb",  int'(sb_if.fwdb),  src_fwd(sb_if.use_rt, int'(sb_if.rt)));
    check("cmp_cnt",   int'(sb_if.stall_cnt), m_cnt);
  end

  task automatic drive(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input bit we, input int dst, input int rdy, input bit a);
    sb_if.id_valid = v;
    sb_if.rs       = RW'(rs);
    sb_if.use_rs   = urs;
    sb_if.rt       = RW'(rt);
    sb_if.use_rt   = urt;
    sb_if.wr_en    = we;
    sb_if.wr_dst   = RW'(dst);
    sb_if.wr_rdy   = AW'(rdy);
    sb_if.adv      = a;
  endtask

  // One ID cycle: new inputs just after the edge, then settle to the falling edge.
  task automatic step(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                      input bit we, input int dst, input int rdy, input bit a);
    @(posedge clk);
    #1;
    drive(v, rs, urs, rt, urt, we, dst, rdy, a);
    @(negedge clk);
  endtask

  task automatic wr(input int dst, input int rdy);
    step(1, 0, 0, 0, 0, 1, dst, rdy, 1);
  endtask

  task automatic rd(input int rs, input bit urs, input int rt, input bit urt, input bit a);
    step(1, rs, urs, rt, urt, 0, 0, 0, a);
  endtask

  initial begin
    clrn = 1'b0;
    drive(1, 3, 1, 3, 1, 0, 0, 0, 1);
    @(negedge clk);
    check("rst_stall", int'(sb_if.stall), 0);
    check("rst_issue", int'(sb_if.issue), 0);
    check("rst_fwda",  int'(sb_if.fwda),  0);
    check("rst_cnt",   int'(sb_if.stall_cnt), 0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // ALU writer forwarded from EX, MEM, WB, then regfile
    wr(3, 1);
    check("alu_issue", int'(sb_if.issue), 1);
    rd(3, 1, 0, 0, 1);
    check("alu_stall", int'(sb_if.stall), 0);
    check("alu_fwd1",  int'(sb_if.fwda),  1);
    rd(3, 1, 0, 0, 1);
    check("alu_fwd2",  int'(sb_if.fwda),  2);
    rd(3, 1, 0, 0, 1);
    check("alu_fwd3",  int'(sb_if.fwda),  3);
    rd(3, 1, 0, 0, 1);
    check("alu_fwd0",  int'(sb_if.fwda),  0);

    // Load-use: one bubble, then forward from MEM
    wr(5, 2);
    rd(0, 0, 5, 1, 1);
    check("ld_stall",  int'(sb_if.stall), 1);
    check("ld_noiss",  int'(sb_if.issue), 0);
    rd(0, 0, 5, 1, 1);
    check("ld_go",     int'(sb_if.stall), 0);
    check("ld_fwdb",   int'(sb_if.fwdb),  2);
    check("ld_issue",  int'(sb_if.issue), 1);
    check("ld_cnt",    int'(sb_if.stall_cnt), 1);

    // r0 is never tracked
    wr(0, 1);
    rd(0, 1, 0, 1, 1);
    check("r0_stall",  int'(sb_if.stall), 0);
    check("r0_fwda",   int'(sb_if.fwda),  0);
    check("r0_fwdb",   int'(sb_if.fwdb),  0);

    // WAW: younger ALU writer shadows older load
    wr(7, 2);
    wr(7, 1);
    rd(7, 1, 0, 0, 1);
    check("waw_stall", int'(sb_if.stall), 0);
    check("waw_fwda",  int'(sb_if.fwda),  1);

    // Freeze: age and counter hold while adv=0
    wr(4, 2);
    for (int i = 0; i < 3; i++) begin
      rd(4, 1, 0, 0, 0);
      check("frz_stall", int'(sb_if.stall), 1);
      check("frz_issue", int'(sb_if.issue), 0);
      check("frz_cnt",   int'(sb_if.stall_cnt), 1);
    end
    rd(4, 1, 0, 0, 1);
    check("frz_rel",   int'(sb_if.stall), 1);
    rd(4, 1, 0, 0, 1);
    check("frz_fwda",  int'(sb_if.fwda),  2);
    check("frz_cnt2",  int'(sb_if.stall_cnt), 2);

    // wr_rdy=0 behaves as 1
    wr(9, 0);
    rd(9, 1, 0, 0, 1);
    check("rdy0_stall", int'(sb_if.stall), 0);
    check("rdy0_fwda",  int'(sb_if.fwda),  1);

    // WB-ready writer, rs==rt
    wr(10, 3);
    rd(10, 1, 10, 1, 1);
    check("wb_stall1", int'(sb_if.stall), 1);
    rd(10, 1, 10, 1, 1);
    check("wb_stall2", int'(sb_if.stall), 1);
    rd(10, 1, 10, 1, 1);
    check("wb_fwda",   int'(sb_if.fwda), 3);
    check("wb_fwdb",   int'(sb_if.fwdb), 3);
    check("wb_cnt",    int'(sb_if.stall_cnt), 4);

    // Reader of its own destination sees the old writer
    wr(12, 1);
    step(1, 12, 1, 0, 0, 1, 12, 2, 1);
    check("self_fwda", int'(sb_if.fwda),  1);
    check("self_iss",  int'(sb_if.issue), 1);
    rd(12, 1, 0, 0, 1);
    check("self_stl",  int'(sb_if.stall), 1);
    rd(12, 1, 0, 0, 1);
    check("self_fwd2", int'(sb_if.fwda),  2);
    check("self_cnt",  int'(sb_if.stall_cnt), 5);

    // Counter saturates at all-ones
    for (int j = 0; j < 2; j++) begin
      wr(14, 3);
      rd(14, 1, 0, 0, 1);
      rd(14, 1, 0, 0, 1);
      rd(14, 1, 0, 0, 1);
    end
    check("sat_cnt",   int'(sb_if.stall_cnt), 7);
    check("sat_fwda",  int'(sb_if.fwda), 3);

    // Mid-run reset with three busy entries
    wr(1, 1);
    wr(2, 2);
    wr(13, 3);
    rd(13, 1, 2, 1, 1);
    check("pre_stall", int'(sb_if.stall), 1);
    #2;
    clrn = 1'b0;
    #1;
    check("mr_stall",  int'(sb_if.stall), 0);
    check("mr_issue",  int'(sb_if.issue), 0);
    check("mr_fwda",   int'(sb_if.fwda),  0);
    check("mr_fwdb",   int'(sb_if.fwdb),  0);
    check("mr_cnt",    int'(sb_if.stall_cnt), 0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    drive(1, 1, 1, 13, 1, 0, 0, 0, 1);
    @(negedge clk);
    check("post_fwda", int'(sb_if.fwda),  0);
    check("post_fwdb", int'(sb_if.fwdb),  0);
    rd(2, 1, 2, 1, 1);
    check("post_r2",   int'(sb_if.fwda),  0);
    check("post_iss",  int'(sb_if.issue), 1);

    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
